// File: rtl/sw_cond_pkg.sv
// sw_cond_pkg: shared state encoding and defaults for the switch input conditioner
package sw_cond_pkg;
  typedef enum logic [1:0] {IDLE, HELD, REL} sw_state_t;
  localparam int DB_CYC_DEFAULT = 16;
endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: two-flop synchroniser plus stability counter for one switch bit
import sw_cond_pkg::*;
module debounce_bit #(
  parameter int DB_CYC = DB_CYC_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int CW = $clog2(DB_CYC + 1);
  logic s1, s2;
  logic [CW-1:0] cnt;
  // sync the raw bit, then only adopt it once it has disagreed with dout for DB_CYC cycles
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      dout <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) cnt <= '0;
      else if (cnt == CW'(DB_CYC - 1)) begin
        dout <= s2;
        cnt  <= '0;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/sw_input_conditioner.sv
// sw_input_conditioner: debounced switch data with hold/release handshake for the CPU
import sw_cond_pkg::*;
module sw_input_conditioner #(
  parameter int NSW    = 10,
  parameter int DB_CYC = DB_CYC_DEFAULT,
  parameter int DW     = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NSW-1:0] sw_raw,
  output logic [DW-1:0]  sw_data,
  output logic           sw_hold,
  output logic           sw_spare,
  output logic           data_strobe,
  output logic           release_strobe
);
  logic [NSW-1:0] db;
  logic db_hold_q, rise, fall;
  sw_state_t state, nxt;
  for (genvar i = 0; i < NSW; i++) begin : g_db
    debounce_bit #(.DB_CYC(DB_CYC)) u_db (.clk(clk), .reset(reset), .din(sw_raw[i]), .dout(db[i]));
  end
  assign rise     = db[DW] & ~db_hold_q;
  assign fall     = ~db[DW] & db_hold_q;
  assign sw_spare = db[NSW-1];
  // hold handshake: capture on rising hold, freeze while held, one release cycle
  always_comb
    nxt = (state == IDLE) ? (rise ? HELD : IDLE) :
          (state == HELD) ? (fall ? REL : HELD) : IDLE;
  // registered state, edge tracker and CPU-facing outputs
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state          <= IDLE;
      db_hold_q      <= 1'b0;
      sw_data        <= '0;
      sw_hold        <= 1'b0;
      data_strobe    <= 1'b0;
      release_strobe <= 1'b0;
    end else begin
      state          <= nxt;
      db_hold_q      <= db[DW];
      sw_data        <= (state == IDLE) ? db[DW-1:0] : sw_data;
      sw_hold        <= nxt == HELD;
      data_strobe    <= (state == IDLE) && rise;
      release_strobe <= (state == HELD) && fall;
    end
endmodule

// File: tb/tb_sw_input_conditioner.sv
// tb_sw_input_conditioner: directed checks of debounce latency, glitch rejection and hold handshake
module tb_sw_input_conditioner;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [9:0] sw_raw = 10'h3FF;
  logic [7:0] sw_data;
  logic sw_hold, sw_spare, data_strobe, release_strobe;
  int checks = 0;
  int errors = 0;

  sw_input_conditioner dut (
    .clk(clk), .reset(reset), .sw_raw(sw_raw), .sw_data(sw_data), .sw_hold(sw_hold),
    .sw_spare(sw_spare), .data_strobe(data_strobe), .release_strobe(release_strobe)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    sw_raw = 10'h3FF;
    tick(3);
    checks++;
    if ({sw_data, sw_hold, sw_spare, data_strobe, release_strobe} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs got data=%h hold=%b spare=%b ds=%b rs=%b want all 0",
               sw_data, sw_hold, sw_spare, data_strobe, release_strobe);
    end
    sw_raw = 10'h000;
    tick(1);
    reset = 1'b1;
    tick(25);
    checks++;
    if (sw_data !== 8'h00) begin
      errors++;
      $display("FAIL reset_idle got %h want 00", sw_data);
    end
  endtask

  task automatic test_latency;
    int early;
    early = 0;
    sw_raw = 10'h0A5;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (sw_data !== 8'h00) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL latency_early got %0d early cycles want 0", early);
    end
    tick(1);
    checks++;
    if (sw_data !== 8'hA5) begin
      errors++;
      $display("FAIL latency_19 got %h want a5", sw_data);
    end
  endtask

  task automatic test_glitch;
    int bad;
    bad = 0;
    sw_raw = 10'h0A4;
    tick(25);
    checks++;
    if (sw_data !== 8'hA4) begin
      errors++;
      $display("FAIL glitch_setup got %h want a4", sw_data);
    end
    sw_raw = 10'h0A5;
    tick(15);
    sw_raw = 10'h0A4;
    for (int k = 0; k < 30; k++) begin
      if (sw_data !== 8'hA4) bad++;
      tick(1);
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL glitch_15 got %0d cycles with bit0 changed want 0", bad);
    end
  endtask

  task automatic test_handshake;
    int early, pulses;
    early = 0;
    pulses = 0;
    sw_raw = 10'h03C;
    tick(20);
    checks++;
    if (sw_data !== 8'h3C) begin
      errors++;
      $display("FAIL hs_data got %h want 3c", sw_data);
    end
    sw_raw = 10'h13C;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (data_strobe || sw_hold) early++;
    end
    tick(1);
    checks++;
    if ({early != 0, data_strobe, sw_hold, sw_data} !== {1'b0, 1'b1, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL hs_capture got early=%0d ds=%b hold=%b data=%h want 0 1 1 3c",
               early, data_strobe, sw_hold, sw_data);
    end
    if (data_strobe) pulses++;
    sw_raw = 10'h1FF;
    for (int k = 0; k < 25; k++) begin
      tick(1);
      if (data_strobe) pulses++;
    end
    checks++;
    if ({pulses, sw_hold, sw_data} !== {32'd1, 1'b1, 8'h3C}) begin
      errors++;
      $display("FAIL hs_frozen got pulses=%0d hold=%b data=%h want 1 1 3c", pulses, sw_hold, sw_data);
    end
    sw_raw = 10'h0FF;
    early = 0;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      if (release_strobe || !sw_hold) early++;
    end
    tick(1);
    checks++;
    if ({early != 0, release_strobe, sw_hold, sw_data} !== {1'b0, 1'b1, 1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL hs_release got early=%0d rs=%b hold=%b data=%h want 0 1 0 3c",
               early, release_strobe, sw_hold, sw_data);
    end
    tick(1);
    checks++;
    if ({release_strobe, sw_data} !== {1'b0, 8'h3C}) begin
      errors++;
      $display("FAIL hs_rel_state got rs=%b data=%h want 0 3c", release_strobe, sw_data);
    end
    tick(1);
    checks++;
    if (sw_data !== 8'hFF) begin
      errors++;
      $display("FAIL hs_after got %h want ff", sw_data);
    end
  endtask

  task automatic test_simultaneous;
    sw_raw = 10'h181;
    tick(19);
    checks++;
    if ({data_strobe, sw_hold, sw_data} !== {1'b1, 1'b1, 8'h81}) begin
      errors++;
      $display("FAIL simul_capture got ds=%b hold=%b data=%h want 1 1 81", data_strobe, sw_hold, sw_data);
    end
    sw_raw = 10'h081;
    tick(25);
    checks++;
    if ({sw_hold, sw_data} !== {1'b0, 8'h81}) begin
      errors++;
      $display("FAIL simul_release got hold=%b data=%h want 0 81", sw_hold, sw_data);
    end
  endtask

  task automatic test_reset_mid_held;
    int pulses;
    pulses = 0;
    sw_raw = 10'h355;
    tick(19);
    checks++;
    if ({sw_hold, sw_spare, sw_data} !== {1'b1, 1'b1, 8'h55}) begin
      errors++;
      $display("FAIL mid_held got hold=%b spare=%b data=%h want 1 1 55", sw_hold, sw_spare, sw_data);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({sw_data, sw_hold, sw_spare, data_strobe, release_strobe} !== 12'h000) begin
      errors++;
      $display("FAIL mid_reset got data=%h hold=%b spare=%b ds=%b rs=%b want all 0",
               sw_data, sw_hold, sw_spare, data_strobe, release_strobe);
    end
    tick(2);
    reset = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      tick(1);
      if (release_strobe) pulses += 100;
      if (data_strobe) begin
        pulses++;
        checks++;
        if ({k, sw_data, sw_hold} !== {32'd19, 8'h55, 1'b1}) begin
          errors++;
          $display("FAIL mid_restrobe got cycle=%0d data=%h hold=%b want 19 55 1", k, sw_data, sw_hold);
        end
      end
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL mid_pulses got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset;
    test_latency;
    test_glitch;
    test_handshake;
    test_simultaneous;
    test_reset_mid_held;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
